// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults and the capture FSM state type for the I2S
// capture block and its helpers.
package i2s_pkg;
  localparam int SAMPLE_W_DEF   = 24;  // valid sample bits per slot, MSB first
  localparam int SLOT_W_DEF     = 32;  // SCK periods per channel slot
  localparam int DEPTH_LOG2_DEF = 9;   // log2 of frames per block

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } state_t;
endpackage

// File: rtl/i2s_edge_sync.sv
// i2s_edge_sync: brings an asynchronous bit clock into the clk domain through
// a 2-FF synchronizer and produces one-cycle rise/fall strobes by comparing
// the synchronized level with its previous value.
// Ports:
//   clk, reset_n   system clock, synchronous active-low reset
//   i_async        asynchronous input (SCK)
//   o_rise/o_fall  one-cycle strobes on synchronized rising/falling edges
module i2s_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic r_s1, r_s2, r_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_prev;
  assign o_fall = ~r_s2 & r_prev;
endmodule

// File: rtl/i2s_capture.sv
// i2s_capture: I2S receiver that deserializes stereo frames and writes them
// into a two-bank frame buffer, handing full banks to a consumer.
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   en                  capture enable (level)
//   sck, sd             I2S bit clock and serial data (asynchronous)
//   ws                  word select, 0 = left slot, 1 = right slot
//   wr_en/wr_addr       one-cycle frame write, address = {bank, frame index}
//   wr_data_l/_r        left/right samples for the write
//   blk_done/blk_bank   pulse when a bank fills / which bank (held)
//   blk_release/rel_bank consumer frees a bank
//   overrun             sticky: frames were dropped because no bank was free
module i2s_capture
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int SLOT_W     = SLOT_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  sck,
  input  logic                  sd,
  output logic                  ws,
  output logic                  wr_en,
  output logic [DEPTH_LOG2:0]   wr_addr,
  output logic [SAMPLE_W-1:0]   wr_data_l,
  output logic [SAMPLE_W-1:0]   wr_data_r,
  output logic                  blk_done,
  output logic                  blk_bank,
  input  logic                  blk_release,
  input  logic                  rel_bank,
  output logic                  overrun
);
  localparam int CNT_W = $clog2(2 * SLOT_W);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_SMP  = CNT_W'(SAMPLE_W);

  logic w_rise, w_fall;

  i2s_edge_sync u_sck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (sck),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // sd gets the same two-stage delay as sck so it is sampled in step
  // with the synchronized rise strobe.
  logic r_sd_s1, r_sd_s2;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [SAMPLE_W-1:0]   r_shift, r_left;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_bank;
  logic [1:0]            r_busy;
  logic                  r_ws, r_wr_en, r_blk_done, r_blk_bank, r_overrun;
  logic [DEPTH_LOG2:0]   r_wr_addr;
  logic [SAMPLE_W-1:0]   r_wr_data_l, r_wr_data_r;

  logic                  w_right, w_wrap, w_shift, w_last_l, w_wr, w_blk_end;
  logic [CNT_W-1:0]      w_idx;
  logic [SAMPLE_W-1:0]   w_sample;
  logic [1:0]            w_set, w_clr, w_busy_nxt;

  assign w_right  = (r_bit_cnt >= CNT_SLOT);
  assign w_idx    = w_right ? (r_bit_cnt - CNT_SLOT) : r_bit_cnt;
  assign w_wrap   = w_fall && (r_bit_cnt == CNT_LAST);
  // Index 0 is the I2S one-bit delay slot; bits past SAMPLE_W are padding.
  assign w_shift  = w_rise && (w_idx != '0) && (w_idx <= CNT_SMP);
  assign w_last_l = w_rise && !w_right && (w_idx == CNT_SMP);
  assign w_wr     = w_rise && w_right && (w_idx == CNT_SMP) && (r_state == ST_RUN);
  assign w_blk_end = w_wr && (r_idx == '1);
  assign w_sample = {r_shift[SAMPLE_W-2:0], r_sd_s2};

  // Set (bank filled) wins over a coincident release of the same bank.
  assign w_set      = {w_blk_end & r_bank, w_blk_end & ~r_bank};
  assign w_clr      = {blk_release & rel_bank, blk_release & ~rel_bank};
  assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (en) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_wrap && !en)
          w_state_nxt = ST_IDLE;
        else if (w_blk_end && w_busy_nxt[~r_bank])
          w_state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (w_wrap) begin
          if (!en)                 w_state_nxt = ST_IDLE;
          else if (!r_busy[r_bank]) w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sd_s1     <= 1'b0;
      r_sd_s2     <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_left      <= '0;
      r_idx       <= '0;
      r_bank      <= 1'b0;
      r_busy      <= '0;
      r_ws        <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data_l <= '0;
      r_wr_data_r <= '0;
      r_blk_done  <= 1'b0;
      r_blk_bank  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sd_s1 <= sd;
      r_sd_s2 <= r_sd_s1;

      if (r_state == ST_IDLE)
        r_bit_cnt <= '0;
      else if (w_fall)
        r_bit_cnt <= w_wrap ? '0 : r_bit_cnt + 1'b1;

      r_ws <= (r_bit_cnt >= CNT_SLOT);

      if (w_shift)  r_shift <= w_sample;
      if (w_last_l) r_left  <= w_sample;

      r_wr_en    <= w_wr;
      r_blk_done <= w_blk_end;
      if (w_wr) begin
        r_wr_addr   <= {r_bank, r_idx};
        r_wr_data_l <= r_left;
        r_wr_data_r <= w_sample;
      end

      // Outside RUN the index sits at 0 so every new run starts a fresh block.
      if (r_state != ST_RUN) r_idx <= '0;
      else if (w_wr)         r_idx <= r_idx + 1'b1;

      if (w_blk_end) begin
        r_bank     <= ~r_bank;
        r_blk_bank <= r_bank;
      end
      r_busy <= w_busy_nxt;

      if (r_state == ST_RUN && w_state_nxt == ST_DROP) r_overrun <= 1'b1;
    end
  end

  assign ws        = r_ws;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data_l = r_wr_data_l;
  assign wr_data_r = r_wr_data_r;
  assign blk_done  = r_blk_done;
  assign blk_bank  = r_blk_bank;
  assign overrun   = r_overrun;
endmodule
